decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clock  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 enable_decode  input  1  stage advance; when high, the stage captures dout and npc_in.
REQ-004 dout  input  16  instruction word from fetch/instruction memory.
REQ-005 npc_in  input  16  next-PC value from fetch, paired with dout.
REQ-006 IR  output  16  registered instruction word.
REQ-007 npc_out  output  16  registered next-PC value.
REQ-008 E_Control  output  6  execute controls: [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select.
REQ-009 Mem_Control  output  1  1 for indirect memory ops (LDI/STI), else 0.
REQ-010 W_Control  output  2  writeback source: 00 ALU, 01 memory, 10 PC (LEA).
REQ-011 decode_valid  output  1  high once at least one instruction has been captured since reset.

Function
REQ-012 On each rising clock edge with enable_decode=1, the stage SHALL register all outputs from dout/npc_in; latency is one cycle.
REQ-013 With enable_decode=0, all outputs SHALL hold their values.
REQ-014 IR SHALL equal the captured dout and npc_out SHALL equal the captured npc_in, unmodified.
REQ-015 alu_control: ADD(0001)=00, AND(0101)=01, NOT(1001)=10, all other opcodes=00.
REQ-016 op2select: 1 for ADD/AND with dout[5]=1 (imm5), else 0.
REQ-017 pcselect1/pcselect2: BR(0000), LD(0010), LDI(1010), ST(0011), STI(1011), LEA(1110)=01/1; LDR(0110), STR(0111)=10/0; JMP(1100)=11/0; all others=00/0.
REQ-018 Resulting E_Control values: ADD reg 6'h00, ADD imm 6'h01, AND reg 6'h10, AND imm 6'h11, NOT 6'h20, BR/LD/LDI/ST/STI/LEA 6'h06, LDR/STR 6'h08, JMP 6'h0C.
REQ-019 W_Control: LD/LDR/LDI=01, LEA=10, all others=00.
REQ-020 Mem_Control: LDI/STI=1, all others=0.
REQ-021 Unsupported opcodes (0100, 1000, 1101, 1111) SHALL decode as E_Control=0, W_Control=00, Mem_Control=0, with IR/npc_out still captured.
REQ-022 decode_valid SHALL be set on the first enabled edge after reset and remain 1 until reset.

Reset
REQ-023 While reset=1, IR, npc_out, E_Control, Mem_Control, W_Control and decode_valid SHALL be 0 immediately, regardless of the clock.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight capture; the first enabled edge after reset deassertion captures fresh data.

Configuration
REQ-025 Macro DECODE_ILLEGAL_DET_EN, when defined, SHALL add outputs illegal_op (1) and illegal_cnt (8).
REQ-026 illegal_op SHALL be registered alongside IR: 1 when the captured opcode is unsupported, else 0; it holds with enable_decode=0.
REQ-027 illegal_cnt SHALL increment on each enabled capture of an unsupported opcode, saturate at 8'hFF, and reset to 0.
REQ-028 Without the macro, neither port nor the counter SHALL exist, and all other behaviour is identical.

Structure
REQ-029 Shared package decode_pkg SHALL hold the opcode enum, the E_Control field typedef, the W_Control encoding constants and the E_Control value constants.
REQ-030 Combinational opcode-to-control mapping SHALL reside in sub-module decode_ctrl_lut; decode_stage owns the registers and counter.

Verification
REQ-031 Reset asserted mid-cycle with outputs nonzero -> all outputs 0 before the next clock edge.
REQ-032 dout=16'h1283, npc_in=16'h3001, enable=1 -> next edge: IR=16'h1283, npc_out=16'h3001, E_Control=6'h00, W_Control=00, Mem_Control=0, decode_valid=1.
REQ-033 dout=16'h1265 (ADD imm), then 16'h6A42 (LDR) -> E_Control 6'h01/W_Control 00, then 6'h08/W_Control 01.
REQ-034 dout=16'hA205 (LDI) -> E_Control=6'h06, W_Control=01, Mem_Control=1; then 16'hE405 (LEA) -> 6'h06, 10, 0.
REQ-035 enable_decode=0 for 3 cycles while dout changes -> all outputs unchanged.
REQ-036 dout=16'hF025 (TRAP) -> E_Control=0, W_Control=0, Mem_Control=0; with DECODE_ILLEGAL_DET_EN, illegal_op=1 and illegal_cnt=1; 300 consecutive captures -> illegal_cnt=8'hFF.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode types and constants: opcode enum, E_Control field layout,
// W_Control encodings and the full E_Control value set.
package decode_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [1:0] alu_control;
    logic [1:0] pcselect1;
    logic       pcselect2;
    logic       op2select;
  } e_control_t;

  localparam logic [1:0] W_ALU = 2'b00;
  localparam logic [1:0] W_MEM = 2'b01;
  localparam logic [1:0] W_PC  = 2'b10;

  localparam e_control_t E_ADD_REG = 6'h00;
  localparam e_control_t E_ADD_IMM = 6'h01;
  localparam e_control_t E_AND_REG = 6'h10;
  localparam e_control_t E_AND_IMM = 6'h11;
  localparam e_control_t E_NOT     = 6'h20;
  localparam e_control_t E_PCREL   = 6'h06;
  localparam e_control_t E_BASEREL = 6'h08;
  localparam e_control_t E_JMP     = 6'h0C;
  localparam e_control_t E_NONE    = 6'h00;

  function automatic logic is_unsupported(input opcode_e op);
    return (op == OP_JSR) || (op == OP_RTI) || (op == OP_RES) || (op == OP_TRAP);
  endfunction

endpackage

// File: rtl/decode_ctrl_lut.sv
// Combinational opcode-to-control mapping for the decode stage.
// Optional illegal-opcode flag present only with DECODE_ILLEGAL_DET_EN.
module decode_ctrl_lut
  import decode_pkg::*;
(
  input  opcode_e     opcode,
  input  logic        imm_flag,
  output e_control_t  e_control,
  output logic [1:0]  w_control,
  output logic        mem_control
`ifdef DECODE_ILLEGAL_DET_EN
  ,
  output logic        illegal
`endif
);

  always_comb begin
    e_control   = E_NONE;
    w_control   = W_ALU;
    mem_control = 1'b0;
    case (opcode)
      OP_ADD:  e_control = imm_flag ? E_ADD_IMM : E_ADD_REG;
      OP_AND:  e_control = imm_flag ? E_AND_IMM : E_AND_REG;
      OP_NOT:  e_control = E_NOT;
      OP_BR, OP_ST:
               e_control = E_PCREL;
      OP_LD: begin
        e_control = E_PCREL;
        w_control = W_MEM;
      end
      OP_LDI: begin
        e_control   = E_PCREL;
        w_control   = W_MEM;
        mem_control = 1'b1;
      end
      OP_STI: begin
        e_control   = E_PCREL;
        mem_control = 1'b1;
      end
      OP_LEA: begin
        e_control = E_PCREL;
        w_control = W_PC;
      end
      OP_LDR: begin
        e_control = E_BASEREL;
        w_control = W_MEM;
      end
      OP_STR:  e_control = E_BASEREL;
      OP_JMP:  e_control = E_JMP;
      default: ;
    endcase
  end

`ifdef DECODE_ILLEGAL_DET_EN
  assign illegal = is_unsupported(opcode);
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: registers instruction, next-PC and decoded controls.
// Define DECODE_ILLEGAL_DET_EN to add illegal_op / illegal_cnt outputs.
module decode_stage
  import decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic        Mem_Control,
  output logic [1:0]  W_Control,
  output logic        decode_valid
`ifdef DECODE_ILLEGAL_DET_EN
  ,
  output logic        illegal_op,
  output logic [7:0]  illegal_cnt
`endif
);

  e_control_t e_next;
  logic [1:0] w_next;
  logic       m_next;
`ifdef DECODE_ILLEGAL_DET_EN
  logic       ill_next;
`endif

  decode_ctrl_lut u_lut (
    .opcode      (opcode_e'(dout[15:12])),
    .imm_flag    (dout[5]),
    .e_control   (e_next),
    .w_control   (w_next),
    .mem_control (m_next)
`ifdef DECODE_ILLEGAL_DET_EN
    ,
    .illegal     (ill_next)
`endif
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      IR           <= '0;
      npc_out      <= '0;
      E_Control    <= '0;
      Mem_Control  <= 1'b0;
      W_Control    <= '0;
      decode_valid <= 1'b0;
    end else if (enable_decode) begin
      IR           <= dout;
      npc_out      <= npc_in;
      E_Control    <= e_next;
      Mem_Control  <= m_next;
      W_Control    <= w_next;
      decode_valid <= 1'b1;
    end
  end

`ifdef DECODE_ILLEGAL_DET_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_op  <= 1'b0;
      illegal_cnt <= '0;
    end else if (enable_decode) begin
      illegal_op <= ill_next;
      if (ill_next && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + 8'd1;
    end
  end
`endif

endmodule
